fm_pingpong_ctrl: RTL and testbench

- Scheduler for the two-buffer Fragment Memory (FM).
- A producer writes 8-base fragments into one buffer while the other buffer drains one base per cycle toward the kmer buffer.
- Owns per-buffer state, write/read buffer selects, fill levels and flat RAM indices.
- The RAM array and the index → RAM/entry/offset decode are external.

---
 rtl/fm_pingpong_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fm_pingpong_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_pingpong_ctrl.sv
// Ping-pong scheduler for the two-buffer fragment memory, plus its small output FIFO.
// Latency: first base_valid 2 cycles after a buffer goes FULL; then 1 base/cycle.
// Backpressure: frag_ready drops when the write buffer is busy; reads are credit-limited by a 2-entry FIFO.

module fm_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign pop_vld = (count != '0);
  assign pop     = pop_vld && pop_rdy;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_vld) - (AW+1)'(pop);
    end
  end

endmodule

module fm_pingpong_ctrl #(
  parameter int BASE_LEN  = 2,
  parameter int FRAG_LEN  = 8,
  parameter int FRAG_BITS = BASE_LEN * FRAG_LEN,
  parameter int BUF_SIZE  = 32,
  parameter int IDX_LEN   = $clog2(BUF_SIZE),
  parameter int SLOTS     = BUF_SIZE / FRAG_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frag_valid,
  input  logic [FRAG_BITS-1:0]     frag_data,
  input  logic                     frag_last,
  output logic                     frag_ready,
  output logic                     ram_wr_en,
  output logic                     ram_wr_buf,
  output logic [$clog2(SLOTS)-1:0] ram_wr_slot,
  output logic [FRAG_BITS-1:0]     ram_wr_data,
  output logic                     ram_rd_en,
  output logic                     ram_rd_buf,
  output logic [IDX_LEN-1:0]       ram_rd_idx,
  input  logic [BASE_LEN-1:0]      ram_rd_data,
  output logic                     base_valid,
  output logic [BASE_LEN-1:0]      base_data,
  output logic                     base_last,
  input  logic                     base_ready,
  output logic [1:0]               buf_full
);

  localparam int SLOT_W  = $clog2(SLOTS);
  localparam int FRAG_SH = $clog2(FRAG_LEN);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_DRAINING} buf_state_t;

  buf_state_t         state [2];
  logic [IDX_LEN:0]   fill  [2];
  logic [1:0]         seq_end;
  logic               wr_sel;
  logic               rd_sel;
  logic [IDX_LEN-1:0] rd_idx;
  logic               rd_inflight;
  logic               rd_inflight_last;

  logic               wr_acc;
  logic               wr_close;
  logic               rd_avail;
  logic               rd_issue;
  logic               rd_end;
  logic               fifo_pop;
  logic [1:0]         fifo_cnt;
  logic [2:0]         credit_occ;
  logic [BASE_LEN:0]  fifo_out;

  // Write side: the write buffer accepts until it is handed to the reader.
  assign frag_ready  = (state[wr_sel] == S_EMPTY) || (state[wr_sel] == S_FILLING);
  assign wr_acc      = frag_valid && frag_ready;
  assign ram_wr_en   = wr_acc;
  assign ram_wr_buf  = wr_sel;
  assign ram_wr_slot = fill[wr_sel][IDX_LEN-1:FRAG_SH];
  assign ram_wr_data = frag_data;
  assign wr_close    = (ram_wr_slot == SLOT_W'(SLOTS-1)) || frag_last;

  // Read side: count FIFO entries plus the read still in the RAM pipe.
  assign fifo_pop   = base_valid && base_ready;
  assign credit_occ = {1'b0, fifo_cnt} + {2'b00, rd_inflight} - {2'b00, fifo_pop};
  assign rd_avail   = (state[rd_sel] == S_FULL) || (state[rd_sel] == S_DRAINING);
  assign rd_issue   = rd_avail && (credit_occ < 3'd2);
  assign rd_end     = rd_issue && ({1'b0, rd_idx} == (fill[rd_sel] - (IDX_LEN+1)'(1)));
  assign ram_rd_en  = rd_issue;
  assign ram_rd_buf = rd_sel;
  assign ram_rd_idx = rd_idx;

  assign buf_full[0] = (state[0] == S_FULL) || (state[0] == S_DRAINING);
  assign buf_full[1] = (state[1] == S_FULL) || (state[1] == S_DRAINING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= S_EMPTY;
        fill[b]  <= '0;
      end
      seq_end          <= '0;
      wr_sel           <= 1'b0;
      rd_sel           <= 1'b0;
      rd_idx           <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
    end else begin
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_end && seq_end[rd_sel];

      // Write and read never target the same buffer: their state guards are disjoint.
      if (wr_acc) begin
        fill[wr_sel] <= fill[wr_sel] + (IDX_LEN+1)'(FRAG_LEN);
        if (wr_close) begin
          state[wr_sel]   <= S_FULL;
          seq_end[wr_sel] <= frag_last;
          wr_sel          <= ~wr_sel;
        end else begin
          state[wr_sel] <= S_FILLING;
        end
      end

      if (rd_issue) begin
        if (rd_end) begin
          state[rd_sel] <= S_EMPTY;
          fill[rd_sel]  <= '0;
          rd_idx        <= '0;
          rd_sel        <= ~rd_sel;
        end else begin
          state[rd_sel] <= S_DRAINING;
          rd_idx        <= rd_idx + IDX_LEN'(1);
        end
      end
    end
  end

  fm_fifo #(.W(BASE_LEN+1), .DEPTH(2)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (rd_inflight),
    .push_dat ({rd_inflight_last, ram_rd_data}),
    .pop_rdy  (base_ready),
    .pop_vld  (base_valid),
    .pop_dat  (fifo_out),
    .count    (fifo_cnt)
  );

  assign base_data = fifo_out[BASE_LEN-1:0];
  assign base_last = fifo_out[BASE_LEN];

endmodule

// File: tb/tb_fm_pingpong_ctrl.sv
// Bench for fm_pingpong_ctrl: RAM model, base scoreboard, vector table and corner sequences.
module tb_fm_pingpong_ctrl;

  logic        clk;
  logic        rst;
  logic        frag_valid;
  logic [15:0] frag_data;
  logic        frag_last;
  logic        frag_ready;
  logic        ram_wr_en;
  logic        ram_wr_buf;
  logic [1:0]  ram_wr_slot;
  logic [15:0] ram_wr_data;
  logic        ram_rd_en;
  logic        ram_rd_buf;
  logic [4:0]  ram_rd_idx;
  logic [1:0]  ram_rd_data;
  logic        base_valid;
  logic [1:0]  base_data;
  logic        base_last;
  logic        base_ready;
  logic [1:0]  buf_full;

  fm_pingpong_ctrl dut (
    .clk(clk), .rst(rst),
    .frag_valid(frag_valid), .frag_data(frag_data), .frag_last(frag_last), .frag_ready(frag_ready),
    .ram_wr_en(ram_wr_en), .ram_wr_buf(ram_wr_buf), .ram_wr_slot(ram_wr_slot), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_buf(ram_rd_buf), .ram_rd_idx(ram_rd_idx), .ram_rd_data(ram_rd_data),
    .base_valid(base_valid), .base_data(base_data), .base_last(base_last), .base_ready(base_ready),
    .buf_full(buf_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External fragment RAM: fragment-wide writes, one-cycle base reads.
  logic [1:0] mem [2][32];
  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 32; i++) mem[b][i] = 2'b00;
    ram_rd_data = 2'b00;
  end
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int i = 0; i < 8; i++) mem[ram_wr_buf][{ram_wr_slot, 3'(i)}] <= ram_wr_data[2*i +: 2];
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_buf][ram_rd_idx];
  end

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q [$];
  int outstanding, pop_cnt, last_cnt, first_pop, last_pop, cyc;
  logic stall_prev;
  logic [1:0] prev_dat;
  logic prev_last;

  typedef struct {
    logic        fv;
    logic [15:0] fd;
    logic        fl;
    logic        br;
    logic        e_frdy;
    logic        e_wen;
    logic        e_wbuf;
    logic [1:0]  e_slot;
    logic [1:0]  e_full;
    logic        e_ren;
    logic        e_bv;
  } vec_t;
  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    exp_q.delete();
    outstanding = 0; pop_cnt = 0; last_cnt = 0; first_pop = -1; last_pop = -1;
    stall_prev = 1'b0;
  endtask

  // Observe one cycle mid-period, update the scoreboard, advance to next negedge.
  task automatic cycle();
    logic pop;
    logic [2:0] e;
    #2;
    cyc++;
    pop = base_valid && base_ready;
    if (stall_prev) begin
      chk("stall_vld", base_valid, 1'b1);
      chk("stall_dat", base_data, prev_dat);
      chk("stall_last", base_last, prev_last);
    end
    if (pop) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_base: got %0d with empty scoreboard", base_data);
      end else begin
        e = exp_q.pop_front();
        chk("base_data", base_data, e[1:0]);
        chk("base_last", base_last, e[2]);
      end
      pop_cnt++;
      if (base_last) last_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    outstanding = outstanding + int'(ram_rd_en) - int'(pop);
    total++;
    if (outstanding > 2) begin
      bad++;
      $display("FAIL outstanding: got %0d want <=2", outstanding);
    end
    if (frag_valid && frag_ready && !rst) begin
      if (ram_wr_en) chk("wr_data", ram_wr_data, frag_data);
      for (int i = 0; i < 8; i++) exp_q.push_back({frag_last && (i == 7), frag_data[2*i +: 2]});
    end
    stall_prev = base_valid && !base_ready;
    prev_dat   = base_data;
    prev_last  = base_last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    frag_valid = 0; frag_data = 0; frag_last = 0; base_ready = 1; rst = 1;
    repeat (2) @(negedge clk);
    clear_stats();
    rst = 0;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      frag_valid = vt[r].fv; frag_data = vt[r].fd; frag_last = vt[r].fl; base_ready = vt[r].br;
      #1;
      chk($sformatf("row%0d_frdy", r), frag_ready, vt[r].e_frdy);
      chk($sformatf("row%0d_wen", r), ram_wr_en, vt[r].e_wen);
      if (vt[r].e_wen) begin
        chk($sformatf("row%0d_wbuf", r), ram_wr_buf, vt[r].e_wbuf);
        chk($sformatf("row%0d_slot", r), ram_wr_slot, vt[r].e_slot);
      end
      chk($sformatf("row%0d_full", r), buf_full, vt[r].e_full);
      chk($sformatf("row%0d_ren", r), ram_rd_en, vt[r].e_ren);
      chk($sformatf("row%0d_bvld", r), base_valid, vt[r].e_bv);
      cycle();
    end
    frag_valid = 0; frag_data = 0; frag_last = 0;
  endtask

  task automatic write_frags(input int n, input logic [15:0] seed, input logic last_on_final);
    for (int k = 0; k < n; k++) begin
      frag_valid = 1; frag_data = seed + 16'(k) * 16'h3217; frag_last = last_on_final && (k == n-1);
      #1;
      chk("wr_frdy", frag_ready, 1'b1);
      cycle();
    end
    frag_valid = 0; frag_data = 0; frag_last = 0;
  endtask

  task automatic run_until_drained(input int max, input logic toggle);
    logic done;
    logic pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    done = 0;
    for (int k = 0; k < max && !done; k++) begin
      if (toggle) base_ready = pat[k % 4];
      #1;
      if (exp_q.size() == 0 && !base_valid && outstanding == 0) done = 1;
      else cycle();
    end
    base_ready = 1;
    chk("drain_done", done, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;
    cyc = 0;
    clear_stats();
    vt[0]  = '{1, 16'h1B1B, 0, 1, 1, 1, 0, 2'd0, 2'b00, 0, 0};
    vt[1]  = '{1, 16'hE4E4, 0, 1, 1, 1, 0, 2'd1, 2'b00, 0, 0};
    vt[2]  = '{1, 16'h0000, 0, 1, 1, 1, 0, 2'd2, 2'b00, 0, 0};
    vt[3]  = '{1, 16'hFFFF, 0, 1, 1, 1, 0, 2'd3, 2'b00, 0, 0};
    vt[4]  = '{0, 16'h0000, 0, 1, 1, 0, 0, 2'd0, 2'b01, 1, 0};
    vt[5]  = '{0, 16'h0000, 0, 1, 1, 0, 0, 2'd0, 2'b01, 1, 0};
    vt[6]  = '{0, 16'h0000, 0, 1, 1, 0, 0, 2'd0, 2'b01, 1, 1};
    vt[7]  = '{1, 16'h5A5A, 0, 1, 1, 1, 0, 2'd0, 2'b00, 0, 0};
    vt[8]  = '{1, 16'hC3C3, 1, 1, 1, 1, 0, 2'd1, 2'b00, 0, 0};
    vt[9]  = '{0, 16'h0000, 0, 1, 1, 0, 0, 2'd0, 2'b01, 1, 0};
    vt[10] = '{0, 16'h0000, 0, 1, 1, 0, 0, 2'd0, 2'b01, 1, 0};
    vt[11] = '{0, 16'h0000, 0, 1, 1, 0, 0, 2'd0, 2'b01, 1, 1};

    frag_valid = 0; frag_data = 0; frag_last = 0; base_ready = 1; rst = 1;
    #1;
    chk("rst_frdy", frag_ready, 1'b1);
    chk("rst_bvld", base_valid, 1'b0);
    chk("rst_full", buf_full, 2'b00);
    chk("rst_ren", ram_rd_en, 1'b0);
    chk("rst_wen", ram_wr_en, 1'b0);
    chk("rst_bdat", {base_last, base_data}, 3'b000);
    do_reset();

    // 1: one full buffer, latency and gapless drain
    apply_rows(0, 6);
    run_until_drained(100, 0);
    chk("t1_pops", pop_cnt, 32);
    chk("t1_span", last_pop - first_pop + 1, 32);
    chk("t1_lastcnt", last_cnt, 0);
    chk("t1_full_end", buf_full, 2'b00);

    // 2: two buffers back to back
    do_reset();
    write_frags(8, 16'h1357, 0);
    run_until_drained(150, 0);
    chk("t2_pops", pop_cnt, 64);
    chk("t2_span", last_pop - first_pop + 1, 64);
    #1;
    chk("t2_rdsel", ram_rd_buf, 1'b0);

    // 3: early close with frag_last
    do_reset();
    apply_rows(7, 11);
    run_until_drained(100, 0);
    chk("t3_pops", pop_cnt, 16);
    chk("t3_lastcnt", last_cnt, 1);

    // 4: consumer stalls
    do_reset();
    write_frags(4, 16'h8E21, 0);
    run_until_drained(300, 1);
    chk("t4_pops", pop_cnt, 32);

    // 5: both buffers held full, write blocked until buf 0 releases
    do_reset();
    base_ready = 0;
    write_frags(8, 16'h2468, 0);
    frag_valid = 1; frag_data = 16'h9C36; frag_last = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_blk_frdy", frag_ready, 1'b0);
      chk("t5_blk_wen", ram_wr_en, 1'b0);
      chk("t5_blk_full", buf_full, 2'b11);
      cycle();
    end
    base_ready = 1;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      #1;
      chk("t5_wait_frdy", frag_ready, 1'b0);
      if (ram_rd_en && ram_rd_buf == 1'b0 && ram_rd_idx == 5'd31) found = 1;
      cycle();
    end
    chk("t5_release_seen", found, 1'b1);
    #1;
    chk("t5_frdy_rise", frag_ready, 1'b1);
    chk("t5_wen_rise", ram_wr_en, 1'b1);
    cycle();
    frag_valid = 0; frag_data = 0; frag_last = 0;
    run_until_drained(200, 0);
    chk("t5_pops", pop_cnt, 72);
    chk("t5_lastcnt", last_cnt, 1);

    // 6: asynchronous reset in the middle of a drain
    do_reset();
    write_frags(4, 16'h7B1D, 0);
    for (int k = 0; k < 60 && pop_cnt < 10; k++) cycle();
    chk("t6_reached", pop_cnt >= 10, 1'b1);
    #3;
    rst = 1;
    #1;
    chk("t6_bvld", base_valid, 1'b0);
    chk("t6_bdat", {base_last, base_data}, 3'b000);
    chk("t6_ren", ram_rd_en, 1'b0);
    chk("t6_ridx", {ram_rd_buf, ram_rd_idx}, 6'd0);
    chk("t6_wen", ram_wr_en, 1'b0);
    chk("t6_full", buf_full, 2'b00);
    chk("t6_frdy", frag_ready, 1'b1);
    clear_stats();
    @(negedge clk);
    cycle();
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t6_post_bvld", base_valid, 1'b0);
      chk("t6_post_full", buf_full, 2'b00);
      chk("t6_post_frdy", frag_ready, 1'b1);
      cycle();
    end
    chk("t6_post_pops", pop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
